// File: rtl/circle_ctrl.sv
// -----------------------------------------------------------------------------
// circle_ctrl
//
// Control FSM for the Bresenham (midpoint) circle datapath. One full circle is
// drawn per start/done handshake. The FSM drives the datapath's load/step/update
// strobes and the octant select. It reads back offset_x, offset_y and crit to
// decide loop exit and the x-decrement.
//
// State sequence per circle:
//   IDLE -> INIT -> { CHECK -> PLOT x8 -> STEP -> UPDATE } x N -> CHECK -> DONE
//
// Ports
//   clk          clock
//   resetn       synchronous, active-low reset
//   start        level request, sampled only in IDLE
//   done         high in DONE, held until start drops
//   busy         high in every state except IDLE and DONE
//   offset_x     signed x offset from datapath   (OFFSET_X_DW)
//   offset_y     signed y offset from datapath   (OFFSET_Y_DW)
//   crit         signed decision variable        (CRIT_DW)
//   octant_sel   octant mux select, 0 outside PLOT
//   load_x_init  offset_x <= radius
//   load_y_init  offset_y <= 0
//   load_crit    crit <= 1 - radius
//   inc_y        calc_offset_y <= offset_y + 1
//   dec_x        calc_offset_x <= offset_x - 1
//   load_x_next  offset_x <= calc_offset_x
//   load_y_next  offset_y <= calc_offset_y
//   calc_crit    crit update from calc offsets
//
// All outputs are registered. They are decoded from the next state, so each
// output lines up exactly with the state register. This keeps the Moore
// timing and adds no output glitches.
//
// A second module, circle_ctrl_chk, holds simulation-only protocol checks.
// A testbench can attach it to the controller's outputs.
// -----------------------------------------------------------------------------
module circle_ctrl #(
    parameter int OFFSET_X_DW = 10,
    parameter int OFFSET_Y_DW = 9,
    parameter int CRIT_DW     = 10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    output logic                   done,
    output logic                   busy,
    input  logic [OFFSET_X_DW-1:0] offset_x,
    input  logic [OFFSET_Y_DW-1:0] offset_y,
    input  logic [CRIT_DW-1:0]     crit,
    output logic [2:0]             octant_sel,
    output logic                   load_x_init,
    output logic                   load_y_init,
    output logic                   load_crit,
    output logic                   inc_y,
    output logic                   dec_x,
    output logic                   load_x_next,
    output logic                   load_y_next,
    output logic                   calc_crit
);

    // State encoding (kept as plain constants for legacy tool flows)
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_PLOT   = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_UPDATE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Common width for the signed loop-exit compare of offset_y against offset_x
    localparam int CMP_DW = (OFFSET_X_DW > OFFSET_Y_DW) ? OFFSET_X_DW : OFFSET_Y_DW;

    logic [2:0]               state_r;
    logic [2:0]               state_next_s;
    logic [2:0]               oct_cnt_r;
    logic [2:0]               oct_cnt_next_s;

    logic signed [CMP_DW-1:0] x_ext_s;
    logic signed [CMP_DW-1:0] y_ext_s;
    logic                     y_le_x_s;
    logic                     crit_pos_s;

    logic                     done_r;
    logic                     busy_r;
    logic [2:0]               octant_sel_r;
    logic                     load_x_init_r;
    logic                     load_y_init_r;
    logic                     load_crit_r;
    logic                     inc_y_r;
    logic                     dec_x_r;
    logic                     load_x_next_r;
    logic                     load_y_next_r;
    logic                     calc_crit_r;

    logic                     done_next_s;
    logic                     busy_next_s;
    logic [2:0]               octant_sel_next_s;
    logic                     load_x_init_next_s;
    logic                     load_y_init_next_s;
    logic                     load_crit_next_s;
    logic                     inc_y_next_s;
    logic                     dec_x_next_s;
    logic                     load_x_next_next_s;
    logic                     load_y_next_next_s;
    logic                     calc_crit_next_s;

    // Sign-extend both offsets so the compare stays correct once offset_x goes negative
    assign x_ext_s    = CMP_DW'($signed(offset_x));
    assign y_ext_s    = CMP_DW'($signed(offset_y));
    assign y_le_x_s   = (y_ext_s <= x_ext_s);

    // crit > 0 (signed): sign bit clear and not zero
    assign crit_pos_s = ~crit[CRIT_DW-1] & (crit != {CRIT_DW{1'b0}});

    // Next-state and octant counter logic
    always_comb begin
        state_next_s   = state_r;
        oct_cnt_next_s = oct_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_INIT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_INIT: begin
                state_next_s = S_CHECK;
            end
            S_CHECK: begin
                if (y_le_x_s) begin
                    state_next_s   = S_PLOT;
                    oct_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            S_PLOT: begin
                if (oct_cnt_r == 3'd7) begin
                    state_next_s   = S_STEP;
                    oct_cnt_next_s = 3'd0;
                end else begin
                    state_next_s   = S_PLOT;
                    oct_cnt_next_s = oct_cnt_r + 3'd1;
                end
            end
            S_STEP: begin
                state_next_s = S_UPDATE;
            end
            S_UPDATE: begin
                state_next_s = S_CHECK;
            end
            S_DONE: begin
                // No auto-restart: start must drop before another run
                if (start) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s   = S_IDLE;
                oct_cnt_next_s = 3'd0;
            end
        endcase
    end

    // Output decode from the next state, registered below
    always_comb begin
        done_next_s        = 1'b0;
        busy_next_s        = 1'b0;
        octant_sel_next_s  = 3'd0;
        load_x_init_next_s = 1'b0;
        load_y_init_next_s = 1'b0;
        load_crit_next_s   = 1'b0;
        inc_y_next_s       = 1'b0;
        dec_x_next_s       = 1'b0;
        load_x_next_next_s = 1'b0;
        load_y_next_next_s = 1'b0;
        calc_crit_next_s   = 1'b0;
        case (state_next_s)
            S_IDLE: begin
                busy_next_s = 1'b0;
            end
            S_INIT: begin
                busy_next_s        = 1'b1;
                load_x_init_next_s = 1'b1;
                load_y_init_next_s = 1'b1;
                load_crit_next_s   = 1'b1;
            end
            S_CHECK: begin
                busy_next_s = 1'b1;
            end
            S_PLOT: begin
                busy_next_s       = 1'b1;
                octant_sel_next_s = oct_cnt_next_s;
            end
            S_STEP: begin
                // crit is only written in INIT and UPDATE. Its value on the last
                // PLOT cycle is therefore the same pre-update crit seen in STEP.
                busy_next_s  = 1'b1;
                inc_y_next_s = 1'b1;
                dec_x_next_s = crit_pos_s;
            end
            S_UPDATE: begin
                busy_next_s        = 1'b1;
                load_x_next_next_s = 1'b1;
                load_y_next_next_s = 1'b1;
                calc_crit_next_s   = 1'b1;
            end
            S_DONE: begin
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // State, octant counter and registered outputs (synchronous active-low reset)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= S_IDLE;
            oct_cnt_r     <= 3'd0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            octant_sel_r  <= 3'd0;
            load_x_init_r <= 1'b0;
            load_y_init_r <= 1'b0;
            load_crit_r   <= 1'b0;
            inc_y_r       <= 1'b0;
            dec_x_r       <= 1'b0;
            load_x_next_r <= 1'b0;
            load_y_next_r <= 1'b0;
            calc_crit_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            oct_cnt_r     <= oct_cnt_next_s;
            done_r        <= done_next_s;
            busy_r        <= busy_next_s;
            octant_sel_r  <= octant_sel_next_s;
            load_x_init_r <= load_x_init_next_s;
            load_y_init_r <= load_y_init_next_s;
            load_crit_r   <= load_crit_next_s;
            inc_y_r       <= inc_y_next_s;
            dec_x_r       <= dec_x_next_s;
            load_x_next_r <= load_x_next_next_s;
            load_y_next_r <= load_y_next_next_s;
            calc_crit_r   <= calc_crit_next_s;
        end
    end

    assign done        = done_r;
    assign busy        = busy_r;
    assign octant_sel  = octant_sel_r;
    assign load_x_init = load_x_init_r;
    assign load_y_init = load_y_init_r;
    assign load_crit   = load_crit_r;
    assign inc_y       = inc_y_r;
    assign dec_x       = dec_x_r;
    assign load_x_next = load_x_next_r;
    assign load_y_next = load_y_next_r;
    assign calc_crit   = calc_crit_r;

endmodule

// -----------------------------------------------------------------------------
// circle_ctrl_chk
//
// Protocol checker for circle_ctrl outputs. It is not synthesized into the
// controller.
//   - At most one strobe group (init / step / update / done) is active at once.
//   - Each group is complete. dec_x appears only together with inc_y.
//   - A nonzero octant_sel occurs only in a busy, strobe-free cycle.
//   - done and busy are never high together.
//
// Ports: clk, resetn, plus every controller output as an input.
// -----------------------------------------------------------------------------
module circle_ctrl_chk (
    input logic       clk,
    input logic       resetn,
    input logic       done,
    input logic       busy,
    input logic [2:0] octant_sel,
    input logic       load_x_init,
    input logic       load_y_init,
    input logic       load_crit,
    input logic       inc_y,
    input logic       dec_x,
    input logic       load_x_next,
    input logic       load_y_next,
    input logic       calc_crit
);

    logic grp_init_s;
    logic grp_step_s;
    logic grp_upd_s;

    assign grp_init_s = load_x_init | load_y_init | load_crit;
    assign grp_step_s = inc_y | dec_x;
    assign grp_upd_s  = load_x_next | load_y_next | calc_crit;

    // Sample outputs every cycle outside reset and check the strobe protocol
    always @(posedge clk) begin
        if (resetn) begin
            assert ($onehot0({grp_init_s, grp_step_s, grp_upd_s, done}))
                else $error("circle_ctrl_chk: more than one strobe group active");
            assert (!grp_init_s || (load_x_init && load_y_init && load_crit))
                else $error("circle_ctrl_chk: partial init group");
            assert (!grp_upd_s || (load_x_next && load_y_next && calc_crit))
                else $error("circle_ctrl_chk: partial update group");
            assert (!dec_x || inc_y)
                else $error("circle_ctrl_chk: dec_x without inc_y");
            assert ((octant_sel == 3'd0) ||
                    (busy && !grp_init_s && !grp_step_s && !grp_upd_s))
                else $error("circle_ctrl_chk: octant_sel nonzero outside plot");
            assert (!(done && busy))
                else $error("circle_ctrl_chk: done and busy together");
        end
    end

endmodule

// File: tb/tb_circle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_circle_ctrl
//
// Self-checking bench for circle_ctrl. A simple strobe-driven datapath model
// feeds offset_x/offset_y/crit back to the controller. The expected behaviour
// comes from two sources:
//   - a plain midpoint-circle loop, which gives the per-iteration (x, y) and the
//     x-decrement decision;
//   - the cycle timeline from the controller's documented behaviour:
//     INIT at E0, then 11 cycles per iteration, then the final CHECK and DONE.
// -----------------------------------------------------------------------------
module tb_circle_ctrl;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          done;
    logic          busy;
    logic [2:0]    octant_sel;
    logic          load_x_init, load_y_init, load_crit;
    logic          inc_y, dec_x;
    logic          load_x_next, load_y_next, calc_crit;

    logic signed [XW-1:0] dp_x    = '0;
    logic signed [YW-1:0] dp_y    = '0;
    logic signed [CW-1:0] dp_crit = '0;
    logic signed [XW-1:0] dp_cx   = '0;
    logic signed [YW-1:0] dp_cy   = '0;
    int                   radius  = 0;

    int errors = 0;
    int checks = 0;

    // Golden per-iteration values
    int gx   [64];
    int gy   [64];
    bit gdec [64];
    int n_it;

    logic [12:0] obs_vec;

    always #5 clk = ~clk;

    circle_ctrl #(.OFFSET_X_DW(XW), .OFFSET_Y_DW(YW), .CRIT_DW(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .done(done), .busy(busy),
        .offset_x(dp_x), .offset_y(dp_y), .crit(dp_crit), .octant_sel(octant_sel),
        .load_x_init(load_x_init), .load_y_init(load_y_init), .load_crit(load_crit),
        .inc_y(inc_y), .dec_x(dec_x), .load_x_next(load_x_next),
        .load_y_next(load_y_next), .calc_crit(calc_crit)
    );

    circle_ctrl_chk chk (
        .clk(clk), .resetn(resetn), .done(done), .busy(busy), .octant_sel(octant_sel),
        .load_x_init(load_x_init), .load_y_init(load_y_init), .load_crit(load_crit),
        .inc_y(inc_y), .dec_x(dec_x), .load_x_next(load_x_next),
        .load_y_next(load_y_next), .calc_crit(calc_crit)
    );

    assign obs_vec = {done, busy, octant_sel, load_x_init, load_y_init, load_crit,
                      inc_y, dec_x, load_x_next, load_y_next, calc_crit};

    // Datapath model: registers respond to the controller's strobes
    always @(posedge clk) begin
        if (load_x_init) dp_x <= XW'(radius);
        if (load_y_init) dp_y <= '0;
        if (load_crit)   dp_crit <= CW'(1 - radius);
        if (inc_y) begin
            dp_cy <= YW'(int'(dp_y) + 1);
            dp_cx <= dec_x ? XW'(int'(dp_x) - 1) : dp_x;
        end
        if (load_x_next) dp_x <= dp_cx;
        if (load_y_next) dp_y <= dp_cy;
        if (calc_crit) begin
            if (int'(dp_crit) <= 0)
                dp_crit <= CW'(int'(dp_crit) + 2 * int'(dp_cy) + 1);
            else
                dp_crit <= CW'(int'(dp_crit) + 2 * (int'(dp_cy) - int'(dp_cx)) + 1);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Textbook midpoint circle loop
    task automatic golden(input int r);
        int x, y, d;
        x = r; y = 0; d = 1 - r; n_it = 0;
        while (y <= x && n_it < 64) begin
            gx[n_it]   = x;
            gy[n_it]   = y;
            gdec[n_it] = (d > 0);
            y = y + 1;
            if (d > 0) begin
                x = x - 1;
                d = d + 2 * (y - x) + 1;
            end else begin
                d = d + 2 * y + 1;
            end
            n_it++;
        end
    endtask

    // Expected output vector k edges after the edge that accepted start
    function automatic logic [12:0] exp_vec(input int k);
        logic [12:0] v;
        int j, i, p;
        v = 13'd0;
        if (k == 0) begin
            v[11] = 1'b1; v[7] = 1'b1; v[6] = 1'b1; v[5] = 1'b1;
        end else begin
            j = k - 1; i = j / 11; p = j % 11;
            if (i < n_it) begin
                v[11] = 1'b1;
                if (p >= 1 && p <= 8) v[10:8] = 3'(p - 1);
                if (p == 9) begin v[4] = 1'b1; v[3] = gdec[i]; end
                if (p == 10) begin v[2] = 1'b1; v[1] = 1'b1; v[0] = 1'b1; end
            end else if (i == n_it && p == 0) begin
                v[11] = 1'b1;
            end else begin
                v[12] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic run_circle(input int r, input int hold, input bit noisy);
        int last, j, i, p, n_step, n_upd, n_oct7, n_dec, g_dec;
        golden(r);
        radius = r;
        last = 2 + 11 * n_it;
        n_step = 0; n_upd = 0; n_oct7 = 0; n_dec = 0; g_dec = 0;
        for (int q = 0; q < n_it; q++) g_dec += int'(gdec[q]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= last + hold; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            check($sformatf("out_r%0d_k%0d", r, k), 32'(obs_vec), 32'(exp_vec(k)));
            if (k >= 1) begin
                j = k - 1; i = j / 11; p = j % 11;
                if (i < n_it && p >= 1 && p <= 8) begin
                    check($sformatf("pix_x_r%0d_i%0d", r, i), 32'(dp_x), gx[i]);
                    check($sformatf("pix_y_r%0d_i%0d", r, i), 32'(dp_y), gy[i]);
                end
            end
            if (inc_y) n_step++;
            if (dec_x) n_dec++;
            if (load_x_next) n_upd++;
            if (busy && octant_sel == 3'd7) n_oct7++;
            if (k < last)
                start = (hold > 0) ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
            else
                start = (k < last + hold) ? 1'b1 : 1'b0;
        end
        check($sformatf("n_step_r%0d", r), n_step, n_it);
        check($sformatf("n_upd_r%0d", r), n_upd, n_it);
        check($sformatf("n_oct7_r%0d", r), n_oct7, n_it);
        check($sformatf("n_dec_r%0d", r), n_dec, g_dec);
        @(posedge clk); #1;
        check($sformatf("idle_r%0d", r), 32'(obs_vec), 32'd0);
        @(posedge clk); #1;
        check($sformatf("stay_idle_r%0d", r), 32'(obs_vec), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(obs_vec), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 32'(obs_vec), 32'd0);

        // Reset while plotting octant 4
        golden(5);
        radius = 5;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
        end
        check("mid_plot_oct", 32'(octant_sel), 32'd4);
        check("mid_plot_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_out", 32'(obs_vec), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_idle", 32'(obs_vec), 32'd0);

        run_circle(0, 0, 1'b0);
        run_circle(1, 0, 1'b0);
        run_circle(10, 0, 1'b1);
        run_circle(10, 20, 1'b0);
        for (int t = 0; t < 16; t++) begin
            run_circle(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
